// File: rtl/io_map.sv
// Shared memory-map constants and byte helpers for the CPU memory responder.
package io_map;

  localparam logic [1:0]  IO_SEL       = 2'b11;
  localparam logic [17:0] IO_UART_ADDR = 18'h30000;
  localparam logic [17:0] IO_CLK_ADDR  = 18'h30004;

  typedef logic [7:0] byte_t;

  // Little-endian byte lane select of a 32-bit word.
  function automatic byte_t word_byte(logic [31:0] w, logic [1:0] sel);
    return w[{sel, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// First-word-fall-through byte FIFO; a pop on a full FIFO lets a same-cycle push in.
module byte_fifo
  import io_map::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic  clk_i,
  input  logic  rst_ni,
  input  logic  push_i,
  input  byte_t wdata_i,
  input  logic  pop_i,
  output byte_t rdata_o,
  output logic  full_o,
  output logic  empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  byte_t         mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          push_ok, pop_ok;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == FULL_CNT);
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);
  assign rdata_o = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop_ok ? rd_ptr_q + AW'(1) : rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_ok && !pop_ok) begin
      cnt_d = cnt_q + (AW+1)'(1);
    end else if (pop_ok && !push_ok) begin
      cnt_d = cnt_q - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/mem_io_responder.sv
// Far end of the CPU byte bus: 128 KiB RAM plus UART FIFOs, cycle counter and
// program-stop in the I/O window at 0x30000-0x30007.
module mem_io_responder
  import io_map::*;
#(
  parameter int unsigned RAM_ADDR_W = 17,
  parameter int unsigned TX_DEPTH   = 8,
  parameter int unsigned RX_DEPTH   = 8
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] cpu_a,
  input  logic        cpu_wr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        prog_stop,
  output logic        tx_overflow
);

  byte_t       ram [2**RAM_ADDR_W];
  byte_t       ram_rdata_q;
  logic        ram_sel_q, ram_sel_d;
  byte_t       io_rdata_q, io_rdata_d;
  logic [32:0] prev_q;
  logic        prev_vld_q;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] snap_q, snap_d;
  logic        stop_q, stop_d;
  logic        ovf_q, ovf_d;

  logic        io_sel, new_acc;
  logic [17:0] io_addr;
  logic        rx_pop, rx_empty, rx_full;
  byte_t       rx_head;
  logic        tx_push, tx_pop, tx_empty, tx_full;
  byte_t       tx_wdata;

  assign io_sel  = (cpu_a[17:16] == IO_SEL);
  assign io_addr = cpu_a[17:0];
  // Side effects only on a changed bus word, so a stalled CPU cannot repeat pops/pushes.
  assign new_acc = !prev_vld_q || (prev_q != {cpu_a, cpu_wr});
  assign tx_pop  = !tx_empty && tx_ready;

  assign cpu_rdata   = ram_sel_q ? ram_rdata_q : io_rdata_q;
  assign rx_ready    = !rx_full;
  assign tx_valid    = !tx_empty;
  assign prog_stop   = stop_q;
  assign tx_overflow = ovf_q;

  always_comb begin
    ram_sel_d  = ram_sel_q;
    io_rdata_d = io_rdata_q;
    snap_d     = snap_q;
    stop_d     = stop_q;
    rx_pop     = 1'b0;
    tx_push    = 1'b0;
    tx_wdata   = cpu_wdata;
    if (!io_sel) begin
      if (!cpu_wr) begin
        ram_sel_d = 1'b1;
      end
    end else if (!cpu_wr) begin
      ram_sel_d = 1'b0;
      if (io_addr == IO_UART_ADDR) begin
        if (new_acc) begin
          rx_pop     = !rx_empty;
          io_rdata_d = rx_empty ? 8'h00 : rx_head;
        end
      end else if (io_addr[17:2] == IO_CLK_ADDR[17:2]) begin
        if (new_acc && io_addr[1:0] == 2'b00) begin
          snap_d = cnt_q;
        end
        io_rdata_d = word_byte(snap_d, io_addr[1:0]);
      end else begin
        io_rdata_d = 8'h00;
      end
    end else if (!stop_q && new_acc) begin
      if (io_addr == IO_UART_ADDR) begin
        tx_push = (cpu_wdata != 8'h00);
      end else if (io_addr == IO_CLK_ADDR) begin
        stop_d   = 1'b1;
        tx_push  = 1'b1;
        tx_wdata = 8'h00;
      end
    end
    ovf_d = ovf_q | (tx_push && tx_full && !tx_pop);
    cnt_d = stop_q ? cnt_q : cnt_q + 32'd1;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      ram_sel_q  <= 1'b0;
      io_rdata_q <= 8'h00;
      prev_q     <= '0;
      prev_vld_q <= 1'b0;
      cnt_q      <= '0;
      snap_q     <= '0;
      stop_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      ram_sel_q  <= ram_sel_d;
      io_rdata_q <= io_rdata_d;
      prev_q     <= {cpu_a, cpu_wr};
      prev_vld_q <= 1'b1;
      cnt_q      <= cnt_d;
      snap_q     <= snap_d;
      stop_q     <= stop_d;
      ovf_q      <= ovf_d;
    end
  end

  // Unreset synchronous-read RAM; the read register holds during writes.
  always_ff @(posedge clk_in) begin
    if (!io_sel) begin
      if (cpu_wr) begin
        ram[cpu_a[RAM_ADDR_W-1:0]] <= cpu_wdata;
      end else begin
        ram_rdata_q <= ram[cpu_a[RAM_ADDR_W-1:0]];
      end
    end
  end

  byte_fifo #(
    .DEPTH (TX_DEPTH)
  ) u_tx_fifo (
    .clk_i   (clk_in),
    .rst_ni  (rst_in),
    .push_i  (tx_push),
    .wdata_i (tx_wdata),
    .pop_i   (tx_pop),
    .rdata_o (tx_data),
    .full_o  (tx_full),
    .empty_o (tx_empty)
  );

  byte_fifo #(
    .DEPTH (RX_DEPTH)
  ) u_rx_fifo (
    .clk_i   (clk_in),
    .rst_ni  (rst_in),
    .push_i  (rx_valid && rx_ready),
    .wdata_i (rx_data),
    .pop_i   (rx_pop),
    .rdata_o (rx_head),
    .full_o  (rx_full),
    .empty_o (rx_empty)
  );

endmodule
